// File: rtl/vga_pkg.sv
// Shared timing constants and elaboration helpers for the VGA timing generator family.
// Defaults describe 640x480 at 60 Hz with a 25.175 MHz pixel clock.
package vga_pkg;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  function automatic int vga_total(input int display, input int front,
                                   input int sync, input int back);
    return display + front + sync + back;
  endfunction

  // Fewest counter bits able to represent positions 0..n-1.
  function automatic int vga_min_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int vga_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int VGA_H_TOTAL = vga_total(VGA_H_DISPLAY, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK);
  localparam int VGA_V_TOTAL = vga_total(VGA_V_DISPLAY, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK);

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter with registered sync and a
// combinational visible-area decode of the position it is about to hold.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int DISPLAY = VGA_H_DISPLAY,
  parameter int FRONT   = VGA_H_FRONT,
  parameter int SYNC    = VGA_H_SYNC,
  parameter int BACK    = VGA_H_BACK,
  parameter bit POL     = 1'b0,
  parameter int W       = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  output logic [W-1:0] pos,
  output logic         wrap,
  output logic         sync,
  output logic         active
);

  localparam int TOTAL = vga_total(DISPLAY, FRONT, SYNC, BACK);

  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
  localparam logic [W:0]   DISP_END = (W+1)'(DISPLAY);
  localparam logic [W:0]   SYNC_BEG = (W+1)'(DISPLAY + FRONT);
  localparam logic [W:0]   SYNC_END = (W+1)'(DISPLAY + FRONT + SYNC);

  if (SYNC < 1) begin : g_sync_width_check
    $error("vga_axis_counter: SYNC must be at least 1");
  end

  if (TOTAL > 2**W) begin : g_width_check
    $error("vga_axis_counter: W too narrow for DISPLAY+FRONT+SYNC+BACK");
  end

  logic [W-1:0] pos_q, pos_d;
  logic [W:0]   pos_ext;
  logic         sync_q, sync_d;

  // Next position, wrap strobe and decodes taken from the next position so
  // that every registered output lines up with the position it describes.
  always_comb begin
    pos_d  = pos_q;
    wrap   = 1'b0;
    sync_d = sync_q;
    if (step) begin
      if (pos_q == LAST) begin
        pos_d = {W{1'b0}};
        wrap  = 1'b1;
      end else begin
        pos_d = pos_q + W'(1);
      end
    end else begin
      pos_d = pos_q;
    end
    pos_ext = {1'b0, pos_d};
    active  = (pos_ext < DISP_END);
    if (step) begin
      sync_d = ((pos_ext >= SYNC_BEG) && (pos_ext < SYNC_END)) ? POL : ~POL;
    end else begin
      sync_d = sync_q;
    end
  end

  // Position and sync registers; reset parks on the last position so the
  // first step lands on 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= LAST;
      sync_q <= ~POL;
    end else begin
      pos_q  <= pos_d;
      sync_q <= sync_d;
    end
  end

  assign pos  = pos_q;
  assign sync = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: chained H/V axis counters plus
// registered visible flag, line/frame strobes and a wrapping frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 10,
  parameter int FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic [CNT_W-1:0]   hpos,
  output logic [CNT_W-1:0]   vpos,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL   = vga_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL   = vga_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int MAX_TOTAL = vga_max(H_TOTAL, V_TOTAL);

  if (vga_min_width(MAX_TOTAL) > CNT_W) begin : g_cnt_w_check
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  if ((H_SYNC < 1) || (V_SYNC < 1)) begin : g_sync_check
    $error("vga_timing_gen: H_SYNC and V_SYNC must be at least 1");
  end

  logic h_wrap, v_wrap, h_active, v_active;

  vga_axis_counter #(
    .DISPLAY (H_DISPLAY),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .POL     (HSYNC_POL),
    .W       (CNT_W)
  ) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .step    (pix_en),
    .pos     (hpos),
    .wrap    (h_wrap),
    .sync    (hsync),
    .active  (h_active)
  );

  // The vertical axis only moves when the line wraps, so vsync is line-based.
  vga_axis_counter #(
    .DISPLAY (V_DISPLAY),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .POL     (VSYNC_POL),
    .W       (CNT_W)
  ) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .step    (h_wrap),
    .pos     (vpos),
    .wrap    (v_wrap),
    .sync    (vsync),
    .active  (v_active)
  );

  logic               display_on_q, display_on_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  // Strobes follow the wraps directly, so they fall to 0 whenever pix_en is low.
  always_comb begin
    line_start_d  = h_wrap;
    frame_start_d = h_wrap & v_wrap;
    if (pix_en) begin
      display_on_d = h_active & v_active;
    end else begin
      display_on_d = display_on_q;
    end
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + FRAME_W'(1);
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Output registers; frame_cnt resets to all ones so the first frame reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_on_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= {FRAME_W{1'b1}};
    end else begin
      display_on_q  <= display_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign display_on  = display_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, a tiny timing with
// divided pixel enable, and an active-high sync variant with mid-frame reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic pix_en_a, pix_en_b, pix_en_c;

  logic       hs_a, vs_a, de_a, ls_a, fs_a;
  logic [9:0] hp_a, vp_a;
  logic [7:0] fc_a;

  logic       hs_b, vs_b, de_b, ls_b, fs_b;
  logic [3:0] hp_b, vp_b;
  logic [1:0] fc_b;

  logic       hs_c, vs_c, de_c, ls_c, fs_c;
  logic [9:0] hp_c, vp_c;
  logic [7:0] fc_c;

  int n_cmp = 0;
  int n_err = 0;

  vga_timing_gen u_dut_a (
    .clk (clk), .rst_n (rst_n), .pix_en (pix_en_a),
    .hsync (hs_a), .vsync (vs_a), .display_on (de_a),
    .hpos (hp_a), .vpos (vp_a),
    .line_start (ls_a), .frame_start (fs_a), .frame_cnt (fc_a)
  );

  vga_timing_gen #(
    .H_DISPLAY (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
    .V_DISPLAY (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .CNT_W (4), .FRAME_W (2)
  ) u_dut_b (
    .clk (clk), .rst_n (rst_n), .pix_en (pix_en_b),
    .hsync (hs_b), .vsync (vs_b), .display_on (de_b),
    .hpos (hp_b), .vpos (vp_b),
    .line_start (ls_b), .frame_start (fs_b), .frame_cnt (fc_b)
  );

  vga_timing_gen #(
    .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
    .HSYNC_POL (1'b1), .VSYNC_POL (1'b1)
  ) u_dut_c (
    .clk (clk), .rst_n (rst_n), .pix_en (pix_en_c),
    .hsync (hs_c), .vsync (vs_c), .display_on (de_c),
    .hpos (hp_c), .vpos (vp_c),
    .line_start (ls_c), .frame_start (fs_c), .frame_cnt (fc_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int h, v, adv, fs_first, fs_second;

    rst_n = 1'b0;
    pix_en_a = 1'b0;
    pix_en_b = 1'b0;
    pix_en_c = 1'b0;
    tick();
    tick();

    chk("a_rst_hpos", 32'(hp_a), 32'd799);
    chk("a_rst_vpos", 32'(vp_a), 32'd524);
    chk("a_rst_de", 32'(de_a), 32'd0);
    chk("a_rst_hs", 32'(hs_a), 32'd1);
    chk("a_rst_vs", 32'(vs_a), 32'd1);
    chk("a_rst_ls", 32'(ls_a), 32'd0);
    chk("a_rst_fs", 32'(fs_a), 32'd0);
    chk("a_rst_fc", 32'(fc_a), 32'd255);
    chk("b_rst_fc", 32'(fc_b), 32'd3);
    chk("c_rst_hs", 32'(hs_c), 32'd0);
    chk("c_rst_vs", 32'(vs_c), 32'd0);

    rst_n = 1'b1;
    tick();
    tick();
    chk("a_idle_hpos", 32'(hp_a), 32'd799);
    chk("a_idle_hs", 32'(hs_a), 32'd1);

    // Default timing, one full line plus the first pixel of line 1.
    pix_en_a = 1'b1;
    tick();
    chk("a_first_hpos", 32'(hp_a), 32'd0);
    chk("a_first_vpos", 32'(vp_a), 32'd0);
    chk("a_first_de", 32'(de_a), 32'd1);
    chk("a_first_fs", 32'(fs_a), 32'd1);
    chk("a_first_ls", 32'(ls_a), 32'd1);
    chk("a_first_fc", 32'(fc_a), 32'd0);
    chk("a_first_hs", 32'(hs_a), 32'd1);
    for (int i = 1; i < 800; i++) begin
      tick();
      chk("a_line_hpos", 32'(hp_a), 32'(i));
      chk("a_line_de", 32'(de_a), 32'(i < 640));
      chk("a_line_hs", 32'(hs_a), 32'(!((i >= 656) && (i < 752))));
      chk("a_line_ls", 32'(ls_a), 32'd0);
      chk("a_line_fs", 32'(fs_a), 32'd0);
    end
    tick();
    chk("a_l1_hpos", 32'(hp_a), 32'd0);
    chk("a_l1_vpos", 32'(vp_a), 32'd1);
    chk("a_l1_ls", 32'(ls_a), 32'd1);
    chk("a_l1_fs", 32'(fs_a), 32'd0);
    chk("a_l1_fc", 32'(fc_a), 32'd0);
    chk("a_l1_vs", 32'(vs_a), 32'd1);

    pix_en_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("a_hold_hpos", 32'(hp_a), 32'd0);
      chk("a_hold_vpos", 32'(vp_a), 32'd1);
      chk("a_hold_ls", 32'(ls_a), 32'd0);
      chk("a_hold_de", 32'(de_a), 32'd1);
    end

    // Tiny timing, continuous pix_en: 8x6 = 48 pixels per frame, frame_cnt mod 4.
    do_reset();
    pix_en_b = 1'b1;
    for (int k = 0; k <= 192; k++) begin
      tick();
      h = k % 8;
      v = (k / 8) % 6;
      chk("b_hpos", 32'(hp_b), 32'(h));
      chk("b_vpos", 32'(vp_b), 32'(v));
      chk("b_hs", 32'(hs_b), 32'(!((h == 5) || (h == 6))));
      chk("b_vs", 32'(vs_b), 32'(v != 4));
      chk("b_de", 32'(de_b), 32'((h < 4) && (v < 3)));
      chk("b_ls", 32'(ls_b), 32'(h == 0));
      chk("b_fs", 32'(fs_b), 32'((h == 0) && (v == 0)));
      chk("b_fc", 32'(fc_b), 32'((k / 48) % 4));
    end

    // Tiny timing, pix_en alternating: one advance every two clocks.
    pix_en_b = 1'b0;
    do_reset();
    adv = -1;
    fs_first = -1;
    fs_second = -1;
    for (int c = 0; c < 200; c++) begin
      pix_en_b = ((c % 2) == 0);
      tick();
      if (pix_en_b) adv++;
      h = adv % 8;
      v = (adv / 8) % 6;
      chk("bt_hpos", 32'(hp_b), 32'(h));
      chk("bt_vpos", 32'(vp_b), 32'(v));
      chk("bt_ls", 32'(ls_b), 32'(pix_en_b && (h == 0)));
      chk("bt_fs", 32'(fs_b), 32'(pix_en_b && (h == 0) && (v == 0)));
      chk("bt_fc", 32'(fc_b), 32'((adv / 48) % 4));
      if (fs_b === 1'b1) begin
        if (fs_first < 0) fs_first = c;
        else if (fs_second < 0) fs_second = c;
      end
    end
    chk("bt_frame_period", 32'(fs_second - fs_first), 32'd96);

    // Active-high sync, default H and an 8-line frame, then reset at (300,3).
    pix_en_b = 1'b0;
    do_reset();
    pix_en_c = 1'b1;
    for (int k = 0; k <= 9100; k++) begin
      tick();
      h = k % 800;
      v = (k / 800) % 8;
      chk("c_hpos", 32'(hp_c), 32'(h));
      chk("c_vpos", 32'(vp_c), 32'(v));
      chk("c_hs", 32'(hs_c), 32'((h >= 656) && (h < 752)));
      chk("c_vs", 32'(vs_c), 32'((v == 5) || (v == 6)));
      chk("c_fs", 32'(fs_c), 32'((h == 0) && (v == 0)));
      chk("c_fc", 32'(fc_c), 32'(k / 6400));
    end

    rst_n = 1'b0;
    #1;
    chk("c_arst_hpos", 32'(hp_c), 32'd799);
    chk("c_arst_vpos", 32'(vp_c), 32'd7);
    chk("c_arst_hs", 32'(hs_c), 32'd0);
    chk("c_arst_vs", 32'(vs_c), 32'd0);
    chk("c_arst_de", 32'(de_c), 32'd0);
    chk("c_arst_ls", 32'(ls_c), 32'd0);
    chk("c_arst_fs", 32'(fs_c), 32'd0);
    chk("c_arst_fc", 32'(fc_c), 32'd255);
    tick();
    tick();
    tick();
    chk("c_rst_hold_hpos", 32'(hp_c), 32'd799);
    rst_n = 1'b1;
    tick();
    chk("c_restart_hpos", 32'(hp_c), 32'd0);
    chk("c_restart_vpos", 32'(vp_c), 32'd0);
    chk("c_restart_fs", 32'(fs_c), 32'd1);
    chk("c_restart_ls", 32'(ls_c), 32'd1);
    chk("c_restart_fc", 32'(fc_c), 32'd0);
    chk("c_restart_de", 32'(de_c), 32'd1);

    pix_en_c = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
